// File: rtl/ibex_ss_pkg.sv
// ibex_ss_pkg
//   Shared definitions for the Ibex super system:
//   - rsp_src_e : source of a fetch response (RAM, debug memory, decode error)
//   - MEM_* / DBG_* : address-map base/mask constants, also used by the bus config
package ibex_ss_pkg;

  // Fetch response source, captured alongside the grant
  typedef enum logic [1:0] {
    RSP_MEM = 2'd0,
    RSP_DBG = 2'd1,
    RSP_ERR = 2'd2
  } rsp_src_e;

  // Address map
  localparam logic [31:0] MEM_START = 32'h0010_0000;
  localparam logic [31:0] MEM_MASK  = 32'hFFFF_0000;
  localparam logic [31:0] DBG_START = 32'h1A11_0000;
  localparam logic [31:0] DBG_MASK  = 32'hFFFF_0000;

  // Address decode helper: true when addr falls inside the window base/mask
  function automatic logic addr_hit(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] mask);
    return ((addr & mask) == base);
  endfunction

endpackage

// File: rtl/instr_dbg_port_arbiter.sv
// instr_dbg_port_arbiter
//   Routes Ibex instruction fetches to the RAM fetch port or to the debug-module
//   memory, arbitrates the single debug-memory slave port between the bus device
//   port (DbgDev, absolute priority) and the fetch path, and owns the fetch
//   response sequencing (rvalid, rdata mux, decode-error flag). Fetches to debug
//   memory held off by device traffic are counted and reported as starvation.
// Ports
//   clk_sys_i, rst_sys_ni          : clock, async active-low reset
//   instr_req_i/addr_i             : core fetch request
//   instr_gnt_o                    : fetch accepted (combinational)
//   instr_rvalid_o/rdata_o/err_o   : fetch response, one cycle after grant
//   ram_req_o/addr_o, ram_rdata_i  : RAM fetch port (data 1 cycle after req)
//   dev_req_i/we_i/be_i/addr_i/wdata_i : DbgDev device request (never stalled)
//   dev_rvalid_o/rdata_o           : DbgDev response, one cycle after req
//   dbg_req_o/we_o/be_o/addr_o/wdata_o, dbg_rdata_i : debug-memory slave port
//   fetch_starve_o                 : debug fetch blocked >= StarveThresh cycles
module instr_dbg_port_arbiter
  import ibex_ss_pkg::*;
#(
  parameter int unsigned AddrWidth    = 32,
  parameter int unsigned DataWidth    = 32,
  parameter logic [31:0] MemStart     = MEM_START,
  parameter logic [31:0] MemMask      = MEM_MASK,
  parameter logic [31:0] DbgStart     = DBG_START,
  parameter logic [31:0] DbgMask      = DBG_MASK,
  parameter int unsigned CntWidth     = 4,
  parameter int unsigned StarveThresh = 8
) (
  input  logic                 clk_sys_i,
  input  logic                 rst_sys_ni,
  // core fetch interface
  input  logic                 instr_req_i,
  input  logic [AddrWidth-1:0] instr_addr_i,
  output logic                 instr_gnt_o,
  output logic                 instr_rvalid_o,
  output logic [DataWidth-1:0] instr_rdata_o,
  output logic                 instr_err_o,
  // RAM fetch port
  output logic                 ram_req_o,
  output logic [AddrWidth-1:0] ram_addr_o,
  input  logic [DataWidth-1:0] ram_rdata_i,
  // DbgDev bus device port
  input  logic                 dev_req_i,
  input  logic                 dev_we_i,
  input  logic [3:0]           dev_be_i,
  input  logic [AddrWidth-1:0] dev_addr_i,
  input  logic [DataWidth-1:0] dev_wdata_i,
  output logic                 dev_rvalid_o,
  output logic [DataWidth-1:0] dev_rdata_o,
  // debug-memory slave port
  output logic                 dbg_req_o,
  output logic                 dbg_we_o,
  output logic [3:0]           dbg_be_o,
  output logic [AddrWidth-1:0] dbg_addr_o,
  output logic [DataWidth-1:0] dbg_wdata_o,
  input  logic [DataWidth-1:0] dbg_rdata_i,
  // status
  output logic                 fetch_starve_o
);

  localparam logic [CntWidth-1:0] CntMax      = {CntWidth{1'b1}};
  localparam logic [CntWidth-1:0] StarveLimit = CntWidth'(StarveThresh);

  logic                w_mem_hit;
  logic                w_dbg_win;
  logic                w_dbg_hit;
  logic                w_unmapped;
  logic                w_fetch_dbg_gnt;
  logic                w_starve_inc;
  logic                w_cnt_clr;
  logic [CntWidth-1:0] w_cnt_d;
  rsp_src_e            w_rsp_src;

  logic                r_rsp_valid;
  rsp_src_e            r_rsp_src;
  logic                r_dev_rvalid;
  logic [CntWidth-1:0] r_cnt;
  logic                r_starve;

  // Address decode; RAM wins when both windows match
  assign w_mem_hit  = addr_hit(32'(instr_addr_i), MemStart, MemMask);
  assign w_dbg_win  = addr_hit(32'(instr_addr_i), DbgStart, DbgMask);
  assign w_dbg_hit  = w_dbg_win & ~w_mem_hit;
  assign w_unmapped = ~w_mem_hit & ~w_dbg_win;

  // A debug fetch only gets the port when the device is idle this cycle
  assign w_fetch_dbg_gnt = instr_req_i & w_dbg_hit & ~dev_req_i;

  assign instr_gnt_o = instr_req_i & (w_mem_hit | w_unmapped | (w_dbg_hit & ~dev_req_i));

  assign ram_req_o  = instr_req_i & w_mem_hit;
  assign ram_addr_o = instr_addr_i;

  // Debug-port request mux: device traffic overrides the fetch path
  always_comb begin
    dbg_req_o   = dev_req_i | w_fetch_dbg_gnt;
    dbg_we_o    = 1'b0;
    dbg_be_o    = 4'hF;
    dbg_addr_o  = instr_addr_i;
    dbg_wdata_o = '0;
    if (dev_req_i) begin
      dbg_we_o    = dev_we_i;
      dbg_be_o    = dev_be_i;
      dbg_addr_o  = dev_addr_i;
      dbg_wdata_o = dev_wdata_i;
    end else begin
      dbg_we_o    = 1'b0;
      dbg_be_o    = 4'hF;
      dbg_addr_o  = instr_addr_i;
      dbg_wdata_o = '0;
    end
  end

  // Response source for the current fetch
  always_comb begin
    w_rsp_src = RSP_ERR;
    if (w_mem_hit) begin
      w_rsp_src = RSP_MEM;
    end else if (w_dbg_hit) begin
      w_rsp_src = RSP_DBG;
    end else begin
      w_rsp_src = RSP_ERR;
    end
  end

  // Starvation counter next value: saturating increment while blocked by the
  // device, cleared once the fetch is served or withdrawn
  assign w_starve_inc = instr_req_i & w_dbg_hit & dev_req_i;
  assign w_cnt_clr    = w_fetch_dbg_gnt | ~instr_req_i;

  always_comb begin
    w_cnt_d = r_cnt;
    if (w_starve_inc) begin
      if (r_cnt == CntMax) begin
        w_cnt_d = r_cnt;
      end else begin
        w_cnt_d = r_cnt + CntWidth'(1);
      end
    end else if (w_cnt_clr) begin
      w_cnt_d = '0;
    end else begin
      w_cnt_d = r_cnt;
    end
  end

  // Response stage, device rvalid pipe and starvation state
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_src    <= RSP_MEM;
      r_dev_rvalid <= 1'b0;
      r_cnt        <= '0;
      r_starve     <= 1'b0;
    end else begin
      r_rsp_valid  <= instr_gnt_o;
      r_rsp_src    <= w_rsp_src;
      r_dev_rvalid <= dev_req_i;
      r_cnt        <= w_cnt_d;
      // Flag registered from the next count so it tracks r_cnt >= limit
      r_starve     <= (w_cnt_d >= StarveLimit);
    end
  end

  // Fetch response data mux; decode errors return zero
  always_comb begin
    instr_rdata_o = '0;
    case (r_rsp_src)
      RSP_MEM: instr_rdata_o = ram_rdata_i;
      RSP_DBG: instr_rdata_o = dbg_rdata_i;
      RSP_ERR: instr_rdata_o = '0;
      default: instr_rdata_o = '0;
    endcase
  end

  assign instr_rvalid_o = r_rsp_valid;
  assign instr_err_o    = r_rsp_valid & (r_rsp_src == RSP_ERR);
  assign dev_rvalid_o   = r_dev_rvalid;
  assign dev_rdata_o    = dbg_rdata_i;
  assign fetch_starve_o = r_starve;

endmodule

// File: tb/tb_instr_dbg_port_arbiter.sv
// tb_instr_dbg_port_arbiter
//   Directed bench for instr_dbg_port_arbiter: RAM fetch, debug fetch, device
//   priority, starvation flag, unmapped fetch, pipelined traffic and reset.
module tb_instr_dbg_port_arbiter;

  logic        clk_sys_i;
  logic        rst_sys_ni;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        instr_err_o;
  logic        ram_req_o;
  logic [31:0] ram_addr_o;
  logic [31:0] ram_rdata_i;
  logic        dev_req_i;
  logic        dev_we_i;
  logic [3:0]  dev_be_i;
  logic [31:0] dev_addr_i;
  logic [31:0] dev_wdata_i;
  logic        dev_rvalid_o;
  logic [31:0] dev_rdata_o;
  logic        dbg_req_o;
  logic        dbg_we_o;
  logic [3:0]  dbg_be_o;
  logic [31:0] dbg_addr_o;
  logic [31:0] dbg_wdata_o;
  logic [31:0] dbg_rdata_i;
  logic        fetch_starve_o;

  int total;
  int bad;

  instr_dbg_port_arbiter dut (
    .clk_sys_i      (clk_sys_i),
    .rst_sys_ni     (rst_sys_ni),
    .instr_req_i    (instr_req_i),
    .instr_addr_i   (instr_addr_i),
    .instr_gnt_o    (instr_gnt_o),
    .instr_rvalid_o (instr_rvalid_o),
    .instr_rdata_o  (instr_rdata_o),
    .instr_err_o    (instr_err_o),
    .ram_req_o      (ram_req_o),
    .ram_addr_o     (ram_addr_o),
    .ram_rdata_i    (ram_rdata_i),
    .dev_req_i      (dev_req_i),
    .dev_we_i       (dev_we_i),
    .dev_be_i       (dev_be_i),
    .dev_addr_i     (dev_addr_i),
    .dev_wdata_i    (dev_wdata_i),
    .dev_rvalid_o   (dev_rvalid_o),
    .dev_rdata_o    (dev_rdata_o),
    .dbg_req_o      (dbg_req_o),
    .dbg_we_o       (dbg_we_o),
    .dbg_be_o       (dbg_be_o),
    .dbg_addr_o     (dbg_addr_o),
    .dbg_wdata_o    (dbg_wdata_o),
    .dbg_rdata_i    (dbg_rdata_i),
    .fetch_starve_o (fetch_starve_o)
  );

  initial clk_sys_i = 1'b0;
  always #5 clk_sys_i = ~clk_sys_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk_sys_i);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_sys_ni   = 1'b0;
    instr_req_i  = 1'b0;
    instr_addr_i = 32'h0;
    ram_rdata_i  = 32'h0;
    dev_req_i    = 1'b0;
    dev_we_i     = 1'b0;
    dev_be_i     = 4'h0;
    dev_addr_i   = 32'h0;
    dev_wdata_i  = 32'h0;
    dbg_rdata_i  = 32'h0;

    // reset state
    #3;
    chk("rst_rvalid", 32'(instr_rvalid_o), 32'd0);
    chk("rst_err",    32'(instr_err_o),    32'd0);
    chk("rst_devrv",  32'(dev_rvalid_o),   32'd0);
    chk("rst_starve", 32'(fetch_starve_o), 32'd0);
    tick();
    tick();
    rst_sys_ni = 1'b1;
    tick();

    // 1. RAM fetch
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h0010_0080;
    ram_rdata_i  = 32'hDEAD_BEEF;
    #1;
    chk("t1_gnt",     32'(instr_gnt_o), 32'd1);
    chk("t1_ramreq",  32'(ram_req_o),   32'd1);
    chk("t1_ramaddr", ram_addr_o,       32'h0010_0080);
    chk("t1_dbgreq",  32'(dbg_req_o),   32'd0);
    tick();
    instr_req_i = 1'b0;
    #1;
    chk("t1_rvalid", 32'(instr_rvalid_o), 32'd1);
    chk("t1_rdata",  instr_rdata_o,       32'hDEAD_BEEF);
    chk("t1_err",    32'(instr_err_o),    32'd0);
    tick();
    chk("t1_idle_rvalid", 32'(instr_rvalid_o), 32'd0);

    // 2. debug fetch, device idle
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h1A11_0800;
    #1;
    chk("t2_gnt",     32'(instr_gnt_o), 32'd1);
    chk("t2_dbgreq",  32'(dbg_req_o),   32'd1);
    chk("t2_dbgaddr", dbg_addr_o,       32'h1A11_0800);
    chk("t2_dbgwe",   32'(dbg_we_o),    32'd0);
    chk("t2_dbgbe",   32'(dbg_be_o),    32'hF);
    chk("t2_ramreq",  32'(ram_req_o),   32'd0);
    tick();
    instr_req_i = 1'b0;
    dbg_rdata_i = 32'h0000_006F;
    #1;
    chk("t2_rvalid", 32'(instr_rvalid_o), 32'd1);
    chk("t2_rdata",  instr_rdata_o,       32'h0000_006F);
    chk("t2_err",    32'(instr_err_o),    32'd0);
    tick();

    // 3. device write collides with debug fetch
    dev_req_i    = 1'b1;
    dev_we_i     = 1'b1;
    dev_be_i     = 4'hF;
    dev_addr_i   = 32'h1A11_0100;
    dev_wdata_i  = 32'h0000_0005;
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h1A11_0800;
    #1;
    chk("t3_dbgreq",   32'(dbg_req_o),   32'd1);
    chk("t3_dbgwe",    32'(dbg_we_o),    32'd1);
    chk("t3_dbgaddr",  dbg_addr_o,       32'h1A11_0100);
    chk("t3_dbgwdata", dbg_wdata_o,      32'h0000_0005);
    chk("t3_gnt",      32'(instr_gnt_o), 32'd0);
    tick();
    dev_req_i = 1'b0;
    dev_we_i  = 1'b0;
    #1;
    chk("t3_devrv",   32'(dev_rvalid_o),   32'd1);
    chk("t3_gnt2",    32'(instr_gnt_o),    32'd1);
    chk("t3_norv",    32'(instr_rvalid_o), 32'd0);
    chk("t3_dbgaddr2", dbg_addr_o,         32'h1A11_0800);
    tick();
    instr_req_i = 1'b0;
    #1;
    chk("t3_rvalid", 32'(instr_rvalid_o), 32'd1);
    chk("t3_devrv0", 32'(dev_rvalid_o),   32'd0);
    tick();

    // 4. starvation: device held 10 cycles with a debug fetch pending
    dev_req_i    = 1'b1;
    dev_we_i     = 1'b0;
    dev_addr_i   = 32'h1A11_0200;
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h1A11_0800;
    for (int k = 1; k <= 10; k++) begin
      #1;
      chk($sformatf("t4_starve_c%0d", k), 32'(fetch_starve_o), (k >= 9) ? 32'd1 : 32'd0);
      chk($sformatf("t4_gnt_c%0d", k),    32'(instr_gnt_o),    32'd0);
      tick();
    end
    dev_req_i = 1'b0;
    #1;
    chk("t4_gnt",        32'(instr_gnt_o),    32'd1);
    chk("t4_starve_gnt", 32'(fetch_starve_o), 32'd1);
    tick();
    instr_req_i = 1'b0;
    #1;
    chk("t4_starve_clr", 32'(fetch_starve_o), 32'd0);
    chk("t4_rvalid",     32'(instr_rvalid_o), 32'd1);
    tick();

    // 5. unmapped fetch
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h4000_0000;
    ram_rdata_i  = 32'h1234_5678;
    dbg_rdata_i  = 32'h8765_4321;
    #1;
    chk("t5_gnt",    32'(instr_gnt_o), 32'd1);
    chk("t5_ramreq", 32'(ram_req_o),   32'd0);
    chk("t5_dbgreq", 32'(dbg_req_o),   32'd0);
    tick();
    instr_req_i = 1'b0;
    #1;
    chk("t5_rvalid", 32'(instr_rvalid_o), 32'd1);
    chk("t5_err",    32'(instr_err_o),    32'd1);
    chk("t5_rdata",  instr_rdata_o,       32'h0);
    tick();

    // 6. back-to-back RAM fetches with concurrent device reads
    for (int i = 0; i < 4; i++) begin
      instr_req_i  = 1'b1;
      instr_addr_i = 32'h0010_0000 + 32'(4 * i);
      dev_req_i    = 1'b1;
      dev_we_i     = 1'b0;
      dev_addr_i   = 32'h1A11_0000 + 32'(4 * i);
      ram_rdata_i  = 32'hA000_0000 + 32'(i - 1);
      dbg_rdata_i  = 32'hB000_0000 + 32'(i - 1);
      #1;
      chk($sformatf("t6_gnt_%0d", i),     32'(instr_gnt_o), 32'd1);
      chk($sformatf("t6_dbgaddr_%0d", i), dbg_addr_o,       32'h1A11_0000 + 32'(4 * i));
      if (i > 0) begin
        chk($sformatf("t6_rv_%0d", i),    32'(instr_rvalid_o), 32'd1);
        chk($sformatf("t6_rd_%0d", i),    instr_rdata_o,       32'hA000_0000 + 32'(i - 1));
        chk($sformatf("t6_devrv_%0d", i), 32'(dev_rvalid_o),   32'd1);
        chk($sformatf("t6_devrd_%0d", i), dev_rdata_o,         32'hB000_0000 + 32'(i - 1));
      end
      tick();
    end
    instr_req_i = 1'b0;
    dev_req_i   = 1'b0;
    ram_rdata_i = 32'hA000_0003;
    dbg_rdata_i = 32'hB000_0003;
    #1;
    chk("t6_rv_last",    32'(instr_rvalid_o), 32'd1);
    chk("t6_rd_last",    instr_rdata_o,       32'hA000_0003);
    chk("t6_devrv_last", 32'(dev_rvalid_o),   32'd1);
    tick();

    // reset after a grant drops the in-flight response
    instr_req_i  = 1'b1;
    instr_addr_i = 32'h0010_0010;
    dev_req_i    = 1'b1;
    #1;
    chk("t6r_gnt", 32'(instr_gnt_o), 32'd1);
    tick();
    chk("t6r_rv_pre", 32'(instr_rvalid_o), 32'd1);
    rst_sys_ni = 1'b0;
    #1;
    chk("t6r_rvalid", 32'(instr_rvalid_o), 32'd0);
    chk("t6r_devrv",  32'(dev_rvalid_o),   32'd0);
    chk("t6r_err",    32'(instr_err_o),    32'd0);
    chk("t6r_gnt2",   32'(instr_gnt_o),    32'd1);
    tick();
    rst_sys_ni  = 1'b1;
    instr_req_i = 1'b0;
    dev_req_i   = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
